// File: rtl/ctrl_seq_pkg.sv
// Shared types and default widths for the counter control sequencer.
package ctrl_seq_pkg;

  localparam int unsigned N_DEF     = 4;
  localparam int unsigned LEN_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    UP    = 3'd2,
    HOLD  = 3'd3,
    DOWN  = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/count_model.sv
// Shadow model of the up/down counter with a sticky mismatch flag.
// Only instantiated when CTRL_CHECK_EN is defined.
module count_model
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         seq_start,
  input  state_t       state,
  input  logic [N-1:0] count,
  output logic         mismatch
);

  logic [N-1:0] exp;

  always_ff @(posedge clk) begin
    if (reset) begin
      exp      <= '0;
      mismatch <= 1'b0;
    end else begin
      // The counter acts on the same edge as exp, so compare while both are settled.
      if (seq_start)
        mismatch <= 1'b0;
      else if ((state inside {UP, HOLD, DOWN, DONE}) && (count != exp))
        mismatch <= 1'b1;

      case (state)
        CLEAR:   exp <= '0;
        UP:      exp <= exp + N'(1);
        DOWN:    exp <= exp - N'(1);
        default: exp <= exp;
      endcase
    end
  end

endmodule

// File: rtl/counter_ctrl_seq.sv
// Control sequencer for the up/down counter: clear, count up, hold, count down, done.
// Define CTRL_CHECK_EN to shadow-model the counter and raise a sticky mismatch flag.
module counter_ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] up_len,
  input  logic [LEN_W-1:0] pause_len,
  input  logic [LEN_W-1:0] down_len,
  input  logic [N-1:0]     count,
  output logic             cnt_clr,
  output logic             pause,
  output logic             upDown,
  output logic             busy,
  output logic             done,
  output logic             mismatch
);

  state_t           state, ns;
  state_t           from_up, from_hold, from_down;
  logic [LEN_W-1:0] phc, nphc;
  logic [LEN_W-1:0] up_l, pause_l, down_l;
  logic             accept;

  assign accept = (state == IDLE) && start && !abort;

  // Zero-length phases are skipped by resolving the first non-empty phase ahead.
  always_comb begin
    from_down = (down_l  != '0) ? DOWN : DONE;
    from_hold = (pause_l != '0) ? HOLD : from_down;
    from_up   = (up_l    != '0) ? UP   : from_hold;

    ns = state;
    case (state)
      IDLE:    if (accept) ns = CLEAR;
      CLEAR:   ns = from_up;
      UP:      if (phc == '0) ns = from_hold;
      HOLD:    if (phc == '0) ns = from_down;
      DOWN:    if (phc == '0) ns = DONE;
      DONE:    ns = IDLE;
      default: ns = IDLE;
    endcase
    if (abort && (state != IDLE)) ns = IDLE;

    nphc = '0;
    if (ns == state)
      nphc = phc - LEN_W'(1);
    else begin
      case (ns)
        UP:      nphc = up_l - LEN_W'(1);
        HOLD:    nphc = pause_l - LEN_W'(1);
        DOWN:    nphc = down_l - LEN_W'(1);
        default: nphc = '0;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      phc     <= '0;
      up_l    <= '0;
      pause_l <= '0;
      down_l  <= '0;
      cnt_clr <= 1'b0;
      pause   <= 1'b1;
      upDown  <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= ns;
      phc   <= nphc;
      if (accept) begin
        up_l    <= up_len;
        pause_l <= pause_len;
        down_l  <= down_len;
      end
      cnt_clr <= (ns == CLEAR);
      pause   <= !((ns == UP) || (ns == DOWN));
      upDown  <= (ns != DOWN);
      busy    <= (ns inside {CLEAR, UP, HOLD, DOWN});
      done    <= (ns == DONE);
    end
  end

`ifdef CTRL_CHECK_EN
  count_model #(.N(N)) u_count_model (
    .clk       (clk),
    .reset     (reset),
    .seq_start (accept),
    .state     (state),
    .count     (count),
    .mismatch  (mismatch)
  );
`else
  logic unused_count;
  assign unused_count = ^count;
  assign mismatch     = 1'b0;
`endif

endmodule
